parity_tx_ctrl: RTL
===================

Name: parity_tx_ctrl

Overview:
Sequencing controller that takes parallel words on a valid/ready handshake, computes their parity and shifts each word out serially LSB-first with the parity bit appended. It sits between a word producer and a one-bit serial link. It is the frame-level scheduler around the combinational odd/even parity datapath.

Parameters:
DATA_W, 4, data word width in bits (>=1).
ODD_PARITY, 0, 0 = even parity bit (XOR of data); 1 = odd parity bit (inverted XOR).

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  producer has a word
in_data  input  DATA_W  word to transmit
in_ready  output  1  controller can accept a word this cycle
ser_out  output  1  serial data/parity bit
ser_valid  output  1  ser_out carries a frame bit
frame_start  output  1  high on the first data bit of a frame
frame_end  output  1  high on the parity bit of a frame
parity_bit  output  1  parity of the last accepted word, held until next accept
busy  output  1  frame in progress (state != IDLE)
err_inject  input  1  only present with PARITY_ERR_INJ_EN

Behaviour:
- One clock, clk; reset is synchronous and active-high, on rst.
- Reset state: IDLE. Reset values: ser_out=0, ser_valid=0, frame_start=0, frame_end=0, parity_bit=0, busy=0, bit counter=0, shift register=0.
- in_ready = (state==IDLE) || (state==PAR). It is combinational from state and is forced to 0 while rst=1.
- Accept: in_valid && in_ready at a rising edge. Load the shift register with in_data. Compute the parity bit from in_data and register it into parity_bit. Clear the bit counter. Go to DATA.
- FSM states:
  - IDLE: no accept -> stay; accept -> DATA.
  - DATA: outputs ser_valid=1, ser_out=shift[0], frame_start=(count==0). Each cycle, shift right and count++. When count==DATA_W-1 -> PAR.
  - PAR: outputs ser_valid=1, ser_out=parity_bit, frame_end=1. Accept -> DATA (back-to-back, no gap); else -> IDLE.
- All outputs are registered (state-decoded from registered state and shift register). Accept at edge k puts bit0 on ser_out during cycle k+1.
- Frame length is exactly DATA_W+1 cycles. Sustained throughput is one word per DATA_W+1 cycles with in_valid held high.
- DATA_W=1: DATA lasts one cycle, with frame_start=1 in that cycle, then PAR.
- in_valid while in_ready=0 is not accepted. in_data changes during a frame have no effect on the frame.
- rst mid-frame: the frame is abandoned and the next cycle shows the reset values. No partial parity bit is emitted.
- busy=1 in DATA and PAR.

Optional Feature:
Macro PARITY_ERR_INJ_EN.
- Defined: the err_inject port exists. If err_inject=1 on the accept edge, the registered parity_bit (and the serial parity bit) is inverted for that frame only. Data bits are unaffected.
- Not defined: the port is absent and parity is always correct. Behaviour is otherwise identical.

Test Plan:
1. Reset: assert rst for 2 cycles with in_valid=1 -> in_ready=0, and ser_valid, busy, ser_out, parity_bit all 0; in the first cycle after release, in_ready=1.
2. ODD_PARITY=0, DATA_W=4, single word 4'b1011 -> ser_out over 5 cycles = 1,1,0,1,1; frame_start on cycle 1, frame_end on cycle 5, parity_bit=1; then IDLE with ser_valid=0.
3. ODD_PARITY=1, words 4'b0000 and 4'b1111 back-to-back with in_valid held -> stream 0,0,0,0,1,1,1,1,1,1 with no gap; in_ready high only in IDLE and PAR cycles.
4. All 16 values of in_data with ODD_PARITY=0 and ODD_PARITY=1 -> the serial parity bit equals the XOR (even) or XNOR (odd) of the word; data bits are LSB-first.
5. rst asserted during the 3rd data bit of 4'b0110 -> the next cycle is idle (ser_valid=0, busy=0) with no parity bit emitted; the next word is accepted normally.
6. With PARITY_ERR_INJ_EN, 4'b1011, ODD_PARITY=0, err_inject=1 at accept -> serial parity bit 0; the next frame with err_inject=0 -> correct parity bit 1.

Source files
------------

// File: rtl/parity_tx_ctrl_if.sv
// Word-in / bit-out bundle for parity_tx_ctrl: producer handshake plus serial link and status.
// master = producer/link side, slave = controller side.
interface parity_tx_ctrl_if #(
    parameter int DATA_W = 4
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ser_out;
    logic              ser_valid;
    logic              frame_start;
    logic              frame_end;
    logic              parity_bit;
    logic              busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_out, ser_valid, frame_start, frame_end, parity_bit, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_out, ser_valid, frame_start, frame_end, parity_bit, busy
    );
endinterface

// File: rtl/parity_tx_ctrl.sv
// Frame scheduler: accepts a word, shifts it out LSB-first, then appends its parity bit.
// Optional PARITY_ERR_INJ_EN adds err_inject to invert the parity of the frame accepted with it.
module parity_tx_ctrl #(
    parameter int DATA_W     = 4,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    parity_tx_ctrl_if.slave  bus
`ifdef PARITY_ERR_INJ_EN
    ,
    input  logic             err_inject
`endif
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              parity_reg, parity_next;

    logic in_ready;
    logic accept;
    logic inject;
    logic new_parity;

`ifdef PARITY_ERR_INJ_EN
    assign inject = err_inject;
`else
    assign inject = 1'b0;
`endif

    // PAR also accepts so consecutive frames abut with no idle cycle.
    assign in_ready     = !rst && ((state_reg == IDLE) || (state_reg == PAR));
    assign accept       = bus.in_valid && in_ready;
    assign new_parity   = (^bus.in_data) ^ ODD_PARITY ^ inject;
    assign bus.in_ready = in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            count_reg  <= '0;
            parity_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            count_reg  <= count_next;
            parity_reg <= parity_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        count_next  = count_reg;
        parity_next = parity_reg;
        case (state_reg)
            IDLE: state_next = IDLE;
            DATA: begin
                shift_next = shift_reg >> 1;
                count_next = count_reg + CNT_W'(1);
                if (count_reg == LAST_BIT) begin
                    state_next = PAR;
                end
            end
            PAR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // accept can only be true in IDLE or PAR, so it overrides those transitions
        if (accept) begin
            state_next  = DATA;
            shift_next  = bus.in_data;
            count_next  = '0;
            parity_next = new_parity;
        end
    end

    // Outputs are pure decodes of registered state, so they change only on clock edges.
    always_comb begin
        bus.ser_out     = 1'b0;
        bus.ser_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.busy        = (state_reg != IDLE);
        bus.parity_bit  = parity_reg;
        case (state_reg)
            DATA: begin
                bus.ser_valid   = 1'b1;
                bus.ser_out     = shift_reg[0];
                bus.frame_start = (count_reg == '0);
            end
            PAR: begin
                bus.ser_valid = 1'b1;
                bus.ser_out   = parity_reg;
                bus.frame_end = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
